// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port (AR + R channels)
// between NUM_REQ requesters. One transaction is in flight at a time; the R
// burst is routed back combinationally to the granted requester until r_last.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module axi_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = 2
) (
    input  logic                             aclk,
    input  logic                             areset_n,
    // requester side
    input  logic [NUM_REQ*`ADDR_BITS-1:0]    req_araddr,
    input  logic [NUM_REQ*`LEN_BITS-1:0]     req_arlen,
    input  logic [NUM_REQ*`SIZE_BITS-1:0]    req_arsize,
    input  logic [NUM_REQ*2-1:0]             req_arburst,
    input  logic [NUM_REQ*4-1:0]             req_arcache,
    input  logic [NUM_REQ-1:0]               req_arvalid,
    output logic [NUM_REQ-1:0]               req_arready,
    output logic [`DATA_BITS-1:0]            req_rdata,
    output logic [1:0]                       req_rresp,
    output logic                             req_rlast,
    output logic [NUM_REQ-1:0]               req_rvalid,
    input  logic [NUM_REQ-1:0]               req_rready,
    // AXI master AR channel
    output logic [`ADDR_BITS-1:0]            ar_addr,
    output logic [`LEN_BITS-1:0]             ar_len,
    output logic [`SIZE_BITS-1:0]            ar_size,
    output logic [1:0]                       ar_burst,
    output logic [3:0]                       ar_cache,
    output logic                             ar_valid,
    input  logic                             ar_ready,
    // AXI master R channel
    input  logic [`DATA_BITS-1:0]            r_data,
    input  logic [1:0]                       r_resp,
    input  logic                             r_last,
    input  logic                             r_valid,
    output logic                             r_ready,
    // status
    output logic                             busy,
    output logic [ID_BITS-1:0]               grant_id,
    output logic                             len_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // One extra bit so an overlong burst cannot wrap back onto ar_len.
    localparam int CNT_BITS = `LEN_BITS + 1;

    logic [1:0]              state_r;
    logic [ID_BITS-1:0]      ptr_r;
    logic [ID_BITS-1:0]      grant_id_r;
    logic [CNT_BITS-1:0]     beat_cnt_r;
    logic                    len_err_r;
    logic                    ar_valid_r;
    logic [`ADDR_BITS-1:0]   ar_addr_r;
    logic [`LEN_BITS-1:0]    ar_len_r;
    logic [`SIZE_BITS-1:0]   ar_size_r;
    logic [1:0]              ar_burst_r;
    logic [3:0]              ar_cache_r;

    logic                    win_found_s;
    logic [ID_BITS-1:0]      win_idx_s;
    logic                    grant_fire_s;
    logic                    beat_s;
    logic                    cnt_at_len_s;
    logic                    len_bad_s;
    logic [ID_BITS-1:0]      ptr_next_s;
    logic [CNT_BITS-1:0]     cnt_next_s;
    logic [`ADDR_BITS-1:0]   win_addr_s;
    logic [`LEN_BITS-1:0]    win_len_s;
    logic [`SIZE_BITS-1:0]   win_size_s;
    logic [1:0]              win_burst_s;
    logic [3:0]              win_cache_s;

    // Requester index 'offs' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [ID_BITS-1:0] rr_index(input logic [ID_BITS-1:0] base,
                                                    input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return ID_BITS'(sum);
    endfunction

    // Round-robin search: scanning downward leaves the lowest offset from ptr as winner.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_arvalid[rr_index(ptr_r, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_index(ptr_r, k);
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Fields of the winning requester, ready to be captured on grant.
    always_comb begin
        win_addr_s  = req_araddr [int'(win_idx_s) * `ADDR_BITS +: `ADDR_BITS];
        win_len_s   = req_arlen  [int'(win_idx_s) * `LEN_BITS  +: `LEN_BITS];
        win_size_s  = req_arsize [int'(win_idx_s) * `SIZE_BITS +: `SIZE_BITS];
        win_burst_s = req_arburst[int'(win_idx_s) * 2 +: 2];
        win_cache_s = req_arcache[int'(win_idx_s) * 4 +: 4];
    end

    // Grant, beat and burst-length bookkeeping terms.
    always_comb begin
        grant_fire_s = (state_r == ST_IDLE) && win_found_s;
        beat_s       = (state_r == ST_DATA) && r_valid && r_ready;
        cnt_at_len_s = (beat_cnt_r == {1'b0, ar_len_r});
        if (r_last) begin
            len_bad_s = !cnt_at_len_s;
        end else begin
            len_bad_s = cnt_at_len_s;
        end
        if (grant_id_r == ID_BITS'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_id_r + ID_BITS'(1);
        end
        if (beat_cnt_r == {CNT_BITS{1'b1}}) begin
            cnt_next_s = beat_cnt_r;
        end else begin
            cnt_next_s = beat_cnt_r + CNT_BITS'(1);
        end
    end

    // Accept strobe goes to the winner in the same IDLE cycle it is chosen.
    always_comb begin
        req_arready = '0;
        if (grant_fire_s) begin
            req_arready[win_idx_s] = 1'b1;
        end else begin
            req_arready = '0;
        end
    end

    // R-channel routing: only the granted requester sees valid / drives ready.
    always_comb begin
        req_rvalid = '0;
        r_ready    = 1'b0;
        if (state_r == ST_DATA) begin
            req_rvalid[grant_id_r] = r_valid;
            r_ready                = req_rready[grant_id_r];
        end else begin
            req_rvalid = '0;
            r_ready    = 1'b0;
        end
    end

    // Arbiter FSM, AR field capture, beat counter and sticky length error.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            grant_id_r <= '0;
            beat_cnt_r <= '0;
            len_err_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            ar_addr_r  <= '0;
            ar_len_r   <= '0;
            ar_size_r  <= '0;
            ar_burst_r <= 2'b00;
            ar_cache_r <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_fire_s) begin
                        state_r    <= ST_ADDR;
                        grant_id_r <= win_idx_s;
                        beat_cnt_r <= '0;
                        ar_valid_r <= 1'b1;
                        ar_addr_r  <= win_addr_s;
                        ar_len_r   <= win_len_s;
                        ar_size_r  <= win_size_s;
                        ar_burst_r <= win_burst_s;
                        ar_cache_r <= win_cache_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (ar_ready) begin
                        state_r    <= ST_DATA;
                        ar_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        beat_cnt_r <= cnt_next_s;
                        if (len_bad_s) begin
                            len_err_r <= 1'b1;
                        end else begin
                            len_err_r <= len_err_r;
                        end
                        if (r_last) begin
                            state_r <= ST_IDLE;
                            ptr_r   <= ptr_next_s;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ar_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        ar_addr   = ar_addr_r;
        ar_len    = ar_len_r;
        ar_size   = ar_size_r;
        ar_burst  = ar_burst_r;
        ar_cache  = ar_cache_r;
        ar_valid  = ar_valid_r;
        busy      = (state_r != ST_IDLE);
        grant_id  = grant_id_r;
        len_err   = len_err_r;
        req_rdata = r_data;
        req_rresp = r_resp;
        req_rlast = r_last;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed transactions push expected
// grants, AR fields and R beats; negedge monitors pop and compare.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module tb_axi_rd_arbiter;

    localparam int NR = 4;
    localparam int IB = 2;

    logic                         aclk;
    logic                         areset_n;
    logic [NR*`ADDR_BITS-1:0]     req_araddr;
    logic [NR*`LEN_BITS-1:0]      req_arlen;
    logic [NR*`SIZE_BITS-1:0]     req_arsize;
    logic [NR*2-1:0]              req_arburst;
    logic [NR*4-1:0]              req_arcache;
    logic [NR-1:0]                req_arvalid;
    logic [NR-1:0]                req_arready;
    logic [`DATA_BITS-1:0]        req_rdata;
    logic [1:0]                   req_rresp;
    logic                         req_rlast;
    logic [NR-1:0]                req_rvalid;
    logic [NR-1:0]                req_rready;
    logic [`ADDR_BITS-1:0]        ar_addr;
    logic [`LEN_BITS-1:0]         ar_len;
    logic [`SIZE_BITS-1:0]        ar_size;
    logic [1:0]                   ar_burst;
    logic [3:0]                   ar_cache;
    logic                         ar_valid;
    logic                         ar_ready;
    logic [`DATA_BITS-1:0]        r_data;
    logic [1:0]                   r_resp;
    logic                         r_last;
    logic                         r_valid;
    logic                         r_ready;
    logic                         busy;
    logic [IB-1:0]                grant_id;
    logic                         len_err;

    axi_rd_arbiter #(.NUM_REQ(NR), .ID_BITS(IB)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
        .req_arburst(req_arburst), .req_arcache(req_arcache),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_cache(ar_cache), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
        .r_ready(r_ready), .busy(busy), .grant_id(grant_id), .len_err(len_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int                    idx;
        logic [`ADDR_BITS-1:0] addr;
        logic [`LEN_BITS-1:0]  len;
        logic [`SIZE_BITS-1:0] size;
        logic [1:0]            burst;
        logic [3:0]            cache;
    } ar_exp_t;

    typedef struct {
        int                    idx;
        logic [`DATA_BITS-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } beat_exp_t;

    int        gnt_q[$];
    ar_exp_t   ar_q[$];
    beat_exp_t r_q[$];

    logic [`ADDR_BITS-1:0] f_addr  [NR];
    logic [`LEN_BITS-1:0]  f_len   [NR];
    logic [`SIZE_BITS-1:0] f_size  [NR];
    logic [1:0]            f_burst [NR];
    logic [3:0]            f_cache [NR];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Program requester fields and drive them onto the packed buses.
    task automatic set_req(input int i, input logic [`ADDR_BITS-1:0] a, input int len);
        f_addr[i]  = a;
        f_len[i]   = `LEN_BITS'(len);
        f_size[i]  = `SIZE_BITS'(i + 1);
        f_burst[i] = 2'(i + 1);
        f_cache[i] = 4'(4'hA - i);
        req_araddr [i*`ADDR_BITS +: `ADDR_BITS] = f_addr[i];
        req_arlen  [i*`LEN_BITS  +: `LEN_BITS]  = f_len[i];
        req_arsize [i*`SIZE_BITS +: `SIZE_BITS] = f_size[i];
        req_arburst[i*2 +: 2] = f_burst[i];
        req_arcache[i*4 +: 4] = f_cache[i];
    endtask

    // Run one transaction; request must already be presented in an IDLE cycle.
    task automatic serve(input int idx, input int nbeats, input int ar_wait,
                         input int stall_beat, input int stall_cyc, input bit keep);
        ar_exp_t   ae;
        beat_exp_t be;
        ae.idx = idx; ae.addr = f_addr[idx]; ae.len = f_len[idx];
        ae.size = f_size[idx]; ae.burst = f_burst[idx]; ae.cache = f_cache[idx];
        gnt_q.push_back(idx);
        ar_q.push_back(ae);
        ar_ready = 1'b0;
        @(negedge aclk);
        chk("grant_now", {63'd0, req_arready[idx]}, 64'd1);
        tick();
        if (!keep) req_arvalid[idx] = 1'b0;
        for (int w = 0; w < ar_wait; w++) begin
            r_valid = 1'b1;
            r_data  = 32'hDEAD_0000 + 32'(w);
            @(negedge aclk);
            chk("wait_ar_valid", {63'd0, ar_valid}, 64'd1);
            chk("wait_ar_addr", ar_addr, ae.addr);
            chk("wait_ar_len", ar_len, ae.len);
            chk("wait_r_ready", {63'd0, r_ready}, 64'd0);
            chk("wait_req_rvalid", req_rvalid, 64'd0);
            chk("wait_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        r_valid  = 1'b0;
        ar_ready = 1'b1;
        @(negedge aclk);
        chk("ar_valid_issue", {63'd0, ar_valid}, 64'd1);
        tick();
        ar_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            r_valid = 1'b1;
            r_data  = {8'(idx), 8'(b), 16'hA5C3};
            r_resp  = 2'(b);
            r_last  = (b == nbeats - 1);
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    req_rready = ~onehot(idx);
                    @(negedge aclk);
                    chk("stall_r_ready", {63'd0, r_ready}, 64'd0);
                    chk("stall_rvalid", req_rvalid, onehot(idx));
                    tick();
                end
            end
            req_rready = '1;
            be.idx = idx; be.data = r_data; be.resp = r_resp; be.last = r_last;
            r_q.push_back(be);
            tick();
        end
        r_valid    = 1'b0;
        r_last     = 1'b0;
        req_rready = '0;
    endtask

    // Monitor: grants, AR handshakes and R beats against the expectation queues.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (req_arready !== '0) begin
                if (gnt_q.size() == 0) fail_now("unexpected_grant");
                else chk("grant_onehot", req_arready, onehot(gnt_q.pop_front()));
            end
            if (ar_valid && ar_ready) begin
                if (ar_q.size() == 0) fail_now("unexpected_ar");
                else begin
                    ar_exp_t e;
                    e = ar_q.pop_front();
                    chk("ar_addr", ar_addr, e.addr);
                    chk("ar_len", ar_len, e.len);
                    chk("ar_size", ar_size, e.size);
                    chk("ar_burst", ar_burst, e.burst);
                    chk("ar_cache", ar_cache, e.cache);
                    chk("ar_grant_id", grant_id, e.idx);
                end
            end
            if (r_valid && r_ready) begin
                if (r_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    beat_exp_t e;
                    e = r_q.pop_front();
                    chk("beat_rvalid", req_rvalid, onehot(e.idx));
                    chk("beat_rdata", req_rdata, e.data);
                    chk("beat_rresp", req_rresp, e.resp);
                    chk("beat_rlast", {63'd0, req_rlast}, {63'd0, e.last});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        areset_n = 1'b0;
        req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0;
        req_arcache = '0; req_arvalid = '0; req_rready = '0;
        ar_ready = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; r_valid = 1'b0;
        #12;
        chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant_id", grant_id, 64'd0);
        chk("rst_len_err", {63'd0, len_err}, 64'd0);
        chk("rst_ar_addr", ar_addr, 64'd0);
        tick();
        areset_n = 1'b1;
        tick();

        // Single requester 1, arlen 3.
        set_req(1, 32'h1000_0040, 3);
        req_arvalid[1] = 1'b1;
        serve(1, 4, 0, -1, 0, 1'b0);
        chk("t1_grant_id", grant_id, 64'd1);
        chk("t1_len_err", {63'd0, len_err}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd0);

        // ptr is now 2: with 0 and 2 requesting, 2 wins; 0 then withdraws.
        set_req(0, 32'h2000_0000, 0);
        set_req(2, 32'h2000_0200, 0);
        req_arvalid[0] = 1'b1;
        req_arvalid[2] = 1'b1;
        serve(2, 1, 0, -1, 0, 1'b0);
        req_arvalid[0] = 1'b0;
        tick();
        chk("t2_idle_busy", {63'd0, busy}, 64'd0);

        // Fresh reset, then all four held high: order 0,1,2,3,0 back to back.
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) begin
            set_req(i, 32'h3000_0000 + 32'(i * 16), 0);
        end
        req_arvalid = '1;
        serve(0, 1, 0, -1, 0, 1'b1);
        serve(1, 1, 0, -1, 0, 1'b1);
        serve(2, 1, 0, -1, 0, 1'b1);
        serve(3, 1, 0, -1, 0, 1'b1);
        serve(0, 1, 0, -1, 0, 1'b1);
        req_arvalid = '0;
        tick();

        // ar_ready held low 5 cycles with stray r_valid pulses.
        set_req(3, 32'h4000_1230, 1);
        req_arvalid[3] = 1'b1;
        serve(3, 2, 5, -1, 0, 1'b0);
        chk("t4_len_err", {63'd0, len_err}, 64'd0);

        // Granted requester drops rready for 3 cycles mid-burst.
        set_req(2, 32'h5000_0080, 3);
        req_arvalid[2] = 1'b1;
        serve(2, 4, 0, 1, 3, 1'b0);
        chk("t5_len_err", {63'd0, len_err}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);

        // arlen 3 but r_last on the third beat.
        set_req(1, 32'h6000_0000, 3);
        req_arvalid[1] = 1'b1;
        serve(1, 3, 0, -1, 0, 1'b0);
        chk("t6_len_err_set", {63'd0, len_err}, 64'd1);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        set_req(0, 32'h6000_1000, 1);
        req_arvalid[0] = 1'b1;
        serve(0, 2, 0, -1, 0, 1'b0);
        chk("t6_len_err_sticky", {63'd0, len_err}, 64'd1);

        // Reset asserted in the middle of a DATA burst.
        set_req(1, 32'h7000_0000, 3);
        req_arvalid[1] = 1'b1;
        gnt_q.push_back(1);
        ar_q.push_back('{1, f_addr[1], f_len[1], f_size[1], f_burst[1], f_cache[1]});
        tick();
        req_arvalid[1] = 1'b0;
        ar_ready = 1'b1;
        tick();
        ar_ready   = 1'b0;
        r_valid    = 1'b1;
        r_data     = 32'h7777_0001;
        r_resp     = 2'b00;
        r_last     = 1'b0;
        req_rready = '1;
        r_q.push_back('{1, 32'h7777_0001, 2'b00, 1'b0});
        @(negedge aclk);
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("arst_r_ready", {63'd0, r_ready}, 64'd0);
        chk("arst_req_rvalid", req_rvalid, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_grant_id", grant_id, 64'd0);
        chk("arst_len_err", {63'd0, len_err}, 64'd0);
        chk("arst_ar_addr", ar_addr, 64'd0);
        chk("arst_ar_len", ar_len, 64'd0);
        chk("arst_req_rdata", req_rdata, 64'h7777_0001);
        tick();
        r_valid    = 1'b0;
        req_rready = '0;
        areset_n   = 1'b1;
        tick();
        set_req(0, 32'h8000_0000, 0);
        set_req(2, 32'h8000_0200, 0);
        req_arvalid[0] = 1'b1;
        req_arvalid[2] = 1'b1;
        serve(0, 1, 0, -1, 0, 1'b0);
        req_arvalid[2] = 1'b0;
        tick();
        tick();

        chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
        chk("r_q_empty", 64'(r_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
